output_drain: RTL and testbench

- Drains the PE array result port. It accepts one N-element activation vector per handshake: a row column in FC mode, or the vertical output in CNN/EWS mode.
- Buffers vectors in a small FIFO and packs them into memory-width words. Issues sequential writes with address generation and valid/ready flow control.
- Sits between the PE array output and the activation memory write port. It is driven by the layer controller via start/done.

---
 rtl/output_drain.sv | 248 ++++++++++++++++++++++++
 tb/tb_output_drain.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain.sv
// ----------------------------------------------------------------------------
// output_drain
//
// Purpose:
//   Takes N-element activation vectors from the PE array result port and
//   buffers them in a small vector FIFO. Each buffered vector is split into
//   memory-width words of ELEMS_PER_WORD elements. The words are written to
//   sequential addresses with a valid/ready write port. The layer controller
//   starts a transfer with start and is told it finished through done.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   clear        synchronous abort: back to IDLE, FIFO flushed, no done pulse
//   start        single-cycle pulse, honoured only in IDLE
//   base_addr    first write address, latched on start
//   num_vectors  number of vectors in the transfer, latched on start
//   in_valid     in_array carries a vector
//   in_ready     block accepts the vector this cycle
//   in_array     N_DIM_ARRAY signed elements of ACT_DATA_WIDTH bits
//   wr_valid     write request valid (registered, stable until accepted)
//   wr_ready     memory accepts the write
//   wr_addr      write word address (wraps modulo 2^ADDR_WIDTH)
//   wr_data      packed word, element 0 in the LSBs
//   busy         transfer in progress
//   done         one-cycle pulse at the end of a transfer
// ----------------------------------------------------------------------------
module output_drain #(
   parameter int N_DIM_ARRAY    = 16,
   parameter int ACT_DATA_WIDTH = 8,
   parameter int ELEMS_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             clear,
   input  logic                                             start,
   input  logic [ADDR_WIDTH-1:0]                            base_addr,
   input  logic [15:0]                                      num_vectors,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic signed [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0] in_array,
   output logic                                             wr_valid,
   input  logic                                             wr_ready,
   output logic [ADDR_WIDTH-1:0]                            wr_addr,
   output logic [ELEMS_PER_WORD*ACT_DATA_WIDTH-1:0]         wr_data,
   output logic                                             busy,
   output logic                                             done
);

   localparam int WORDS  = N_DIM_ARRAY / ELEMS_PER_WORD;
   localparam int WORD_W = ELEMS_PER_WORD * ACT_DATA_WIDTH;
   localparam int VEC_W  = N_DIM_ARRAY * ACT_DATA_WIDTH;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W  = PTR_W + 1;
   localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);
   localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   state_t                  state_q,     state_d;
   logic [15:0]             num_q,       num_d;
   logic [15:0]             acc_cnt_q,   acc_cnt_d;    // vectors accepted
   logic [15:0]             vec_cnt_q,   vec_cnt_d;    // vectors fully written
   logic [PTR_W-1:0]        wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q,    rd_ptr_d;
   logic [OCC_W-1:0]        occ_q,       occ_d;
   logic [WIDX_W-1:0]       widx_q,      widx_d;       // word index inside head vector
   logic                    in_ready_q,  in_ready_d;
   logic                    wr_valid_q,  wr_valid_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q,   wr_addr_d;
   logic [WORD_W-1:0]       wr_data_q,   wr_data_d;
   logic                    busy_q,      busy_d;
   logic                    done_q,      done_d;

   // Vector storage; contents need no reset because occupancy gates every read
   logic [VEC_W-1:0]        fifo_mem [FIFO_DEPTH];

   logic                    accept;
   logic                    handshake;
   logic                    pop;
   logic                    push_en;
   logic [VEC_W-1:0]        head_vec;

   assign accept    = in_valid && in_ready_q;
   assign handshake = wr_valid_q && wr_ready;
   assign pop       = handshake && (widx_q == LAST_WIDX);
   assign push_en   = accept && !clear;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      acc_cnt_d = acc_cnt_q;
      vec_cnt_d = vec_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      widx_d    = widx_q;
      wr_addr_d = wr_addr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d     = num_vectors;
               wr_addr_d = base_addr;
               acc_cnt_d = '0;
               vec_cnt_d = '0;
               wr_ptr_d  = '0;
               rd_ptr_d  = '0;
               occ_d     = '0;
               widx_d    = '0;
               state_d   = (num_vectors == 16'd0) ? S_DONE : S_RUN;
            end
         end

         S_RUN: begin
            if (accept) begin
               wr_ptr_d  = wr_ptr_q + 1'b1;
               acc_cnt_d = acc_cnt_q + 16'd1;
            end
            if (handshake) begin
               wr_addr_d = wr_addr_q + 1'b1;
               widx_d    = (widx_q == LAST_WIDX) ? '0 : widx_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_d  = rd_ptr_q + 1'b1;
               vec_cnt_d = vec_cnt_q + 16'd1;
               // 17-bit compare so num_vectors = 65535 cannot overflow
               if (({1'b0, vec_cnt_q} + 17'd1) == {1'b0, num_q}) begin
                  state_d = S_DONE;
               end
            end
            // Push and pop together leave occupancy unchanged
            if (accept && !pop) begin
               occ_d = occ_q + 1'b1;
            end else if (pop && !accept) begin
               occ_d = occ_q - 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything, including a same-cycle start or accept
      if (clear) begin
         state_d   = S_IDLE;
         num_d     = '0;
         acc_cnt_d = '0;
         vec_cnt_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         occ_d     = '0;
         widx_d    = '0;
         wr_addr_d = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs, computed from the next-state values so that they
   // line up with the state they describe. in_ready therefore only rises a
   // cycle after the FIFO stops being full.
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready_d = (state_d == S_RUN) && (occ_d != FULL_OCC) && (acc_cnt_d < num_d);
      wr_valid_d = (state_d == S_RUN) && (occ_d != '0);
      busy_d     = (state_d == S_RUN);
      done_d     = (state_d == S_DONE);

      // Next head vector; a vector pushed into an FIFO that drains to empty
      // this cycle is not in memory yet, so it is forwarded from the input.
      head_vec = fifo_mem[rd_ptr_d];
      if (accept && (wr_ptr_q == rd_ptr_d)) begin
         head_vec = in_array;
      end

      wr_data_d = '0;
      if (wr_valid_d) begin
         wr_data_d = head_vec[int'(widx_d) * WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         fifo_mem[wr_ptr_q] <= in_array;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         acc_cnt_q  <= '0;
         vec_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         widx_q     <= '0;
         in_ready_q <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         acc_cnt_q  <= acc_cnt_d;
         vec_cnt_q  <= vec_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         widx_q     <= widx_d;
         in_ready_q <= in_ready_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_output_drain.sv
// ----------------------------------------------------------------------------
// tb_output_drain
//
// Scoreboard bench for output_drain. Every accepted vector is expanded by a
// reference model into its expected (address, word) writes and queued; a
// monitor on the falling edge pops and compares at each write handshake,
// checks stability while stalled and checks each done pulse.
// ----------------------------------------------------------------------------
module tb_output_drain;

   localparam int N    = 16;
   localparam int ACT  = 8;
   localparam int E    = 4;
   localparam int W    = N / E;
   localparam int AW   = 16;
   localparam int WW   = E * ACT;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
   } wr_t;

   logic                          clk;
   logic                          reset;
   logic                          clear;
   logic                          start;
   logic [AW-1:0]                 base_addr;
   logic [15:0]                   num_vectors;
   logic                          in_valid;
   logic                          in_ready;
   logic signed [N-1:0][ACT-1:0]  in_array;
   logic                          wr_valid;
   logic                          wr_ready;
   logic [AW-1:0]                 wr_addr;
   logic [WW-1:0]                 wr_data;
   logic                          busy;
   logic                          done;

   output_drain #(
      .N_DIM_ARRAY    (N),
      .ACT_DATA_WIDTH (ACT),
      .ELEMS_PER_WORD (E),
      .FIFO_DEPTH     (4),
      .ADDR_WIDTH     (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .start       (start),
      .base_addr   (base_addr),
      .num_vectors (num_vectors),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_array    (in_array),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            errors;
   int            checks;
   wr_t           sb[$];
   int            acc_count;
   int            word_count;
   int            done_count;
   int            exp_done;
   int            cur_num;
   logic [AW-1:0] model_addr;
   logic          prev_stall;
   logic [AW-1:0] prev_addr;
   logic [WW-1:0] prev_data;
   wr_t           mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_vec();
      for (int k = 0; k < N; k++) in_array[k] = ACT'($urandom);
   endtask

   // ------------------------------------------------------------------------
   // Monitor + reference model
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (reset || clear) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", wr_valid, 1'b1);
            chk("stall_addr", wr_addr, prev_addr);
            chk("stall_data", wr_data, prev_data);
         end
         if (in_valid && in_ready) begin
            chk("accept_busy", busy, 1'b1);
            acc_count++;
            // Vector splits into W consecutive words at consecutive addresses
            for (int w = 0; w < W; w++) begin
               mon_e.addr = model_addr;
               for (int j = 0; j < E; j++) mon_e.data[j*ACT +: ACT] = in_array[w*E + j];
               model_addr = model_addr + 1'b1;
               sb.push_back(mon_e);
            end
         end
         if (wr_valid && wr_ready) begin
            word_count++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
               mon_e = sb.pop_front();
               chk("wr_addr", wr_addr, mon_e.addr);
               chk("wr_data", wr_data, mon_e.data);
               $display("write addr=%04h data=%08h", wr_addr, wr_data);
            end
         end
         if (done) begin
            done_count++;
            chk("done_sb_empty", sb.size(), 0);
            chk("done_accepts", acc_count, cur_num);
            chk("done_busy", busy, 1'b0);
            $display("done after %0d vectors", acc_count);
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic do_start(input logic [AW-1:0] base, input logic [15:0] num, input bit expect_done);
      base_addr   = base;
      num_vectors = num;
      cur_num     = num;
      acc_count   = 0;
      model_addr  = base;
      if (expect_done) exp_done++;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_xfer(input logic [AW-1:0] base, input logic [15:0] num,
                           input int p_valid, input int p_ready);
      int d0;
      int w0;
      int budget;
      d0 = done_count;
      w0 = word_count;
      do_start(base, num, 1'b1);
      budget = 0;
      while (done_count == d0 && budget < 3000) begin
         in_valid = (acc_count < cur_num) && ($urandom_range(0, 99) < p_valid);
         wr_ready = ($urandom_range(0, 99) < p_ready);
         rand_vec();
         tick();
         budget++;
      end
      in_valid = 1'b0;
      wr_ready = 1'b0;
      if (done_count == d0) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout: got no done expected done within 3000 cycles");
      end
      chk("xfer_words", word_count - w0, num * W);
   endtask

   initial begin
      int d0;
      int w0;
      int budget;
      errors = 0; checks = 0; acc_count = 0; word_count = 0;
      done_count = 0; exp_done = 0; cur_num = 0; model_addr = '0;
      prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
      reset = 1'b1; clear = 1'b0; start = 1'b0; base_addr = '0;
      num_vectors = '0; in_valid = 1'b0; wr_ready = 1'b0; in_array = '0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wr_addr", wr_addr, 16'h0000);
      chk("rst_wr_data", wr_data, 32'h0);
      reset = 1'b0;
      tick();

      // 1. Basic pack, fixed latency and done timing
      wr_ready = 1'b1;
      do_start(16'h0100, 16'd1, 1'b1);
      chk("t1_in_ready", in_ready, 1'b1);
      for (int k = 0; k < N; k++) in_array[k] = ACT'(k);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t1_latency_valid", wr_valid, 1'b1);
      chk("t1_addr0", wr_addr, 16'h0100);
      chk("t1_data0", wr_data, 32'h03020100);
      repeat (4) tick();
      chk("t1_done", done, 1'b1);
      chk("t1_busy_done", busy, 1'b0);
      tick();
      chk("t1_done_pulse", done, 1'b0);

      // 2. Backpressure: FIFO fills with four vectors, then drains
      wr_ready = 1'b0;
      d0 = done_count;
      w0 = word_count;
      do_start(16'h0100, 16'd8, 1'b1);
      in_valid = 1'b1;
      repeat (12) begin
         rand_vec();
         tick();
      end
      chk("bp_accepts", acc_count, 4);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_wr_valid", wr_valid, 1'b1);
      chk("bp_addr", wr_addr, 16'h0100);
      wr_ready = 1'b1;
      budget = 0;
      while (done_count == d0 && budget < 500) begin
         in_valid = (acc_count < 8);
         rand_vec();
         tick();
         budget++;
      end
      in_valid = 1'b0;
      chk("bp_done_count", done_count - d0, 1);
      chk("bp_words", word_count - w0, 32);
      chk("bp_all_accepted", acc_count, 8);

      // 3. Address wrap
      run_xfer(16'hFFFE, 16'd1, 100, 100);
      chk("wrap_end_addr", wr_addr, 16'h0002);

      // 4. Zero length: in_valid is held high but must be ignored
      in_valid = 1'b1;
      wr_ready = 1'b1;
      w0 = word_count;
      do_start(16'h0300, 16'd0, 1'b1);
      chk("zl_done", done, 1'b1);
      chk("zl_in_ready", in_ready, 1'b0);
      chk("zl_wr_valid", wr_valid, 1'b0);
      tick();
      chk("zl_done_pulse", done, 1'b0);
      repeat (3) tick();
      chk("zl_idle_in_ready", in_ready, 1'b0);
      chk("zl_no_writes", word_count - w0, 0);
      in_valid = 1'b0;

      // 5. Clear after the second handshake of a 2-vector transfer
      wr_ready = 1'b1;
      d0 = done_count;
      w0 = word_count;
      do_start(16'h0100, 16'd2, 1'b0);
      budget = 0;
      while ((word_count - w0) < 2 && budget < 100) begin
         in_valid = (acc_count < 2);
         rand_vec();
         tick();
         budget++;
      end
      chk("clr_reached_two_words", word_count - w0, 2);
      clear = 1'b1;
      wr_ready = 1'b0;
      in_valid = 1'b0;
      tick();
      clear = 1'b0;
      sb.delete();
      chk("clr_wr_valid", wr_valid, 1'b0);
      chk("clr_busy", busy, 1'b0);
      chk("clr_in_ready", in_ready, 1'b0);
      repeat (4) tick();
      chk("clr_no_done", done_count - d0, 0);
      run_xfer(16'h0200, 16'd2, 80, 80);

      // 6. Asynchronous reset during a stalled transfer
      wr_ready = 1'b0;
      do_start(16'h0400, 16'd4, 1'b0);
      in_valid = 1'b1;
      repeat (3) begin
         rand_vec();
         tick();
      end
      chk("ar_busy_before", busy, 1'b1);
      chk("ar_valid_before", wr_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_wr_valid", wr_valid, 1'b0);
      chk("ar_in_ready", in_ready, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_done", done, 1'b0);
      sb.delete();
      acc_count = 0;
      cur_num = 0;
      tick();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("ar_idle_busy", busy, 1'b0);
      chk("ar_idle_in_ready", in_ready, 1'b0);
      chk("ar_idle_wr_valid", wr_valid, 1'b0);
      in_valid = 1'b0;

      // Randomized transfers, including one crossing the address wrap
      run_xfer(16'hFFFD, 16'd3, 70, 60);
      for (int i = 0; i < 6; i++) begin
         run_xfer(AW'($urandom), 16'($urandom_range(1, 6)), 70, 60);
      end

      repeat (3) tick();
      chk("total_done", done_count, exp_done);
      chk("final_sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
